// File: rtl/sc64_pkg.sv
// Shared types for the SDRAM port arbiter: requester ids and arbiter FSM states.
// Requester ids double as bit positions in the req/ack vectors.
package sc64;

   typedef enum bit [1:0] {
      MEM_SRC_N64,
      MEM_SRC_CPU,
      MEM_SRC_DMA,
      __MEM_SRC_END
   } e_mem_src;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } e_mem_arb_state;

   localparam int MEM_SRC_NUM = 3;

   // The other CPU/DMA requester, used to advance the round-robin pointer.
   function automatic logic [1:0] rr_other(input logic [1:0] src);
      return (src == MEM_SRC_CPU) ? 2'(MEM_SRC_DMA) : 2'(MEM_SRC_CPU);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: N64 first unless the starvation skip is raised, then CPU/DMA
// round-robin. Zero latency; no state, no backpressure.
module mem_arb_pick
   import sc64::*;
(
   input  logic [2:0] req,
   input  logic [1:0] rr_ptr,
   input  logic       skip_n64,
   output logic       vld,
   output logic [1:0] winner
);

   logic cd_pending;

   assign cd_pending = req[MEM_SRC_CPU] | req[MEM_SRC_DMA];

   always_comb begin
      vld    = |req;
      winner = MEM_SRC_N64;
      // Skipping N64 only makes sense when someone else is actually waiting.
      if (req[MEM_SRC_N64] && !(skip_n64 && cd_pending)) begin
         winner = MEM_SRC_N64;
      end else if (req[MEM_SRC_CPU] && req[MEM_SRC_DMA]) begin
         winner = rr_ptr;
      end else if (req[MEM_SRC_CPU]) begin
         winner = MEM_SRC_CPU;
      end else if (req[MEM_SRC_DMA]) begin
         winner = MEM_SRC_DMA;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SDRAM port between N64/CPU/DMA; one transfer in flight, mem latency + 2 cycles each.
// Sources wait on a held req level; MEM_ARB_STARVATION_GUARD_EN bounds N64 hogging.
module mem_bus_arbiter
   import sc64::*;
#(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 16
`ifdef MEM_ARB_STARVATION_GUARD_EN
   ,
   parameter int STARVE_LIMIT = 8
`endif
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2:0]              req,
   input  logic [2:0]              write,
   input  logic [3*ADDR_W-1:0]     address,
   input  logic [3*DATA_W-1:0]     wdata,
   input  logic [3*(DATA_W/8)-1:0] wmask,
   output logic [2:0]              ack,
   output logic [DATA_W-1:0]       rdata,
   output logic                    mem_req,
   output logic                    mem_write,
   output logic [ADDR_W-1:0]       mem_address,
   output logic [DATA_W-1:0]       mem_wdata,
   output logic [DATA_W/8-1:0]     mem_wmask,
   input  logic                    mem_ack,
   input  logic [DATA_W-1:0]       mem_rdata
);

   localparam int MASK_W = DATA_W / 8;

   e_mem_arb_state    state;
   e_mem_arb_state    state_next;
   logic              load;
   logic [1:0]        grant;
   logic [1:0]        rr_ptr;
   logic              pick_vld;
   logic [1:0]        pick_src;
   logic              skip_n64;

   logic              sel_write;
   logic [ADDR_W-1:0] sel_address;
   logic [DATA_W-1:0] sel_wdata;
   logic [MASK_W-1:0] sel_wmask;

   mem_arb_pick u_pick (
      .req      (req),
      .rr_ptr   (rr_ptr),
      .skip_n64 (skip_n64),
      .vld      (pick_vld),
      .winner   (pick_src)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      mem_req    = 1'b0;
      ack        = 3'b000;
      case (state)
         S_IDLE: begin
            if (pick_vld) begin
               load       = 1'b1;
               state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            // No arbitration here: gives the acked source a cycle to drop req.
            ack        = 3'b001 << grant;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      sel_write   = write[0];
      sel_address = address[ADDR_W-1:0];
      sel_wdata   = wdata[DATA_W-1:0];
      sel_wmask   = wmask[MASK_W-1:0];
      case (pick_src)
         MEM_SRC_CPU: begin
            sel_write   = write[1];
            sel_address = address[2*ADDR_W-1:ADDR_W];
            sel_wdata   = wdata[2*DATA_W-1:DATA_W];
            sel_wmask   = wmask[2*MASK_W-1:MASK_W];
         end
         MEM_SRC_DMA: begin
            sel_write   = write[2];
            sel_address = address[3*ADDR_W-1:2*ADDR_W];
            sel_wdata   = wdata[3*DATA_W-1:2*DATA_W];
            sel_wmask   = wmask[3*MASK_W-1:2*MASK_W];
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant       <= MEM_SRC_N64;
         rr_ptr      <= MEM_SRC_CPU;
         rdata       <= '0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         mem_wmask   <= '0;
      end else begin
         if (load) begin
            grant       <= pick_src;
            mem_write   <= sel_write;
            mem_address <= sel_address;
            mem_wdata   <= sel_wdata;
            mem_wmask   <= sel_wmask;
         end
         if (state == S_BUSY && mem_ack) begin
            rdata <= mem_rdata;
         end
         if (state == S_DONE && grant != MEM_SRC_N64) begin
            rr_ptr <= rr_other(grant);
         end
      end
   end

`ifdef MEM_ARB_STARVATION_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;
   logic             cd_pending;

   assign cd_pending = req[MEM_SRC_CPU] | req[MEM_SRC_DMA];
   assign skip_n64   = (starve_cnt >= CNT_W'(STARVE_LIMIT));

   // Counts N64 wins that overrode a waiting CPU/DMA; any other outcome resets the streak.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (load) begin
         if (pick_src == MEM_SRC_N64 && cd_pending) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end else begin
            starve_cnt <= '0;
         end
      end else if (!cd_pending) begin
         starve_cnt <= '0;
      end
   end
`else
   assign skip_n64 = 1'b0;
`endif

endmodule
